// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the arbitrated 4-bit adder: operand width, requester
// IDs, result-register state and the packed result word.
package adder_arbiter_pkg;

    localparam int ADD_W = 4;

    typedef enum logic {
        REQ_ID_0 = 1'b0,
        REQ_ID_1 = 1'b1
    } req_id_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic             carry;
        logic [ADD_W-1:0] sum;
        req_id_e          id;
    } result_t;

    function automatic req_id_e other_id(input req_id_e id);
        return (id == REQ_ID_0) ? REQ_ID_1 : REQ_ID_0;
    endfunction

endpackage

// File: rtl/adder_arbiter_adder_4bit.sv
// Shared 4-bit adder, no carry-in; carry-out is bit 4 of the zero-extended sum.
// Latency 0 (pure combinational); no flow control.
module adder_4bit
    import adder_arbiter_pkg::*;
(
    input  logic [ADD_W-1:0] i_a,
    input  logic [ADD_W-1:0] i_b,
    output logic [ADD_W-1:0] o_sum,
    output logic             o_carry
);

    logic [ADD_W:0] w_full_sum;

    assign w_full_sum = {1'b0, i_a} + {1'b0, i_b};
    assign o_sum      = w_full_sum[ADD_W-1:0];
    assign o_carry    = w_full_sum[ADD_W];

endmodule

// File: rtl/adder_arbiter.sv
// Two requesters share one adder through a round-robin arbiter into a single-entry result register.
// Latency 1 cycle, throughput 1/cycle; grants only when the result slot is empty or draining this cycle.
module adder_arbiter
    import adder_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [ADD_W-1:0] req0_a,
    input  logic [ADD_W-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [ADD_W-1:0] req1_a,
    input  logic [ADD_W-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ADD_W-1:0] res_sum,
    output logic             res_carry,
    output logic             res_id
);

    state_e           r_state;
    state_e           w_state_nxt;
    req_id_e          r_ptr;
    req_id_e          w_ptr_nxt;
    result_t          r_res;

    logic             w_can_grant;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_gnt;
    req_id_e          w_gnt_id;
    logic [ADD_W-1:0] w_op_a;
    logic [ADD_W-1:0] w_op_b;
    logic [ADD_W-1:0] w_sum;
    logic             w_carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_ptr   <= REQ_ID_0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Reset masks every grant so nothing is accepted in a reset cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_can_grant = 1'b0;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        if (!rst) begin
            w_can_grant = (r_state == ST_EMPTY) || res_ready;
            w_gnt0 = w_can_grant && req0_valid && (!req1_valid || (r_ptr == REQ_ID_0));
            w_gnt1 = w_can_grant && req1_valid && (!req0_valid || (r_ptr == REQ_ID_1));
        end
        if (w_gnt0 || w_gnt1) begin
            w_state_nxt = ST_FULL;
            w_ptr_nxt   = other_id(w_gnt1 ? REQ_ID_1 : REQ_ID_0);
        end else if ((r_state == ST_FULL) && res_ready) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    assign w_gnt    = w_gnt0 || w_gnt1;
    assign w_gnt_id = w_gnt1 ? REQ_ID_1 : REQ_ID_0;
    assign w_op_a   = w_gnt1 ? req1_a : req0_a;
    assign w_op_b   = w_gnt1 ? req1_b : req0_b;

    adder_4bit u_adder (
        .i_a     (w_op_a),
        .i_b     (w_op_b),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // Result only loads on a grant, so it holds steady under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res <= '0;
        end else if (w_gnt) begin
            r_res.carry <= w_carry;
            r_res.sum   <= w_sum;
            r_res.id    <= w_gnt_id;
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign res_valid  = (r_state == ST_FULL);
    assign res_sum    = r_res.sum;
    assign res_carry  = r_res.carry;
    assign res_id     = r_res.id;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed and randomized checks of the round-robin arbitrated adder.
module tb_adder_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid;
    logic [3:0] req0_a;
    logic [3:0] req0_b;
    logic       req0_ready;
    logic       req1_valid;
    logic [3:0] req1_a;
    logic [3:0] req1_b;
    logic       req1_ready;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_sum;
    logic       res_carry;
    logic       res_id;

    int total;
    int bad;

    adder_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_carry  (res_carry),
        .res_id     (res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; checks happen 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                         input logic v1, input logic [3:0] a1, input logic [3:0] b1,
                         input logic rr);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        res_ready  = rr;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 4'h1, 4'h1, 1'b1, 4'h2, 4'h2, 1'b1);
        total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++;
            $display("FAIL reset_readies: got %b%b want 00", req0_ready, req1_ready); end
        next_cycle();
        next_cycle();
        total++; if (res_valid !== 1'b0) begin bad++;
            $display("FAIL reset_valid: got %b want 0", res_valid); end
        total++; if ({res_carry, res_sum, res_id} !== 6'b0) begin bad++;
            $display("FAIL reset_result: got c=%b s=%h id=%b want 0 0 0", res_carry, res_sum, res_id); end
        drive(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1);
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_basic();
        drive(1'b1, 4'h3, 4'h4, 1'b0, 4'h0, 4'h0, 1'b1);
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++;
            $display("FAIL basic_grant: got %b%b want 10", req0_ready, req1_ready); end
        next_cycle();
        drive(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1);
        total++; if ({res_valid, res_carry, res_sum, res_id} !== {1'b1, 1'b0, 4'h7, 1'b0}) begin bad++;
            $display("FAIL basic_result: got v=%b c=%b s=%h id=%b want 1 0 7 0", res_valid, res_carry, res_sum, res_id); end
        next_cycle();
        total++; if (res_valid !== 1'b0) begin bad++;
            $display("FAIL basic_drain: got v=%b want 0", res_valid); end
    endtask

    // Pointer is at requester 1 after test_basic, but single-valid grants ignore it anyway.
    task automatic test_overflow();
        drive(1'b0, 4'h0, 4'h0, 1'b1, 4'hF, 4'h1, 1'b1);
        total++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin bad++;
            $display("FAIL ovf_grant1: got %b%b want 01", req0_ready, req1_ready); end
        next_cycle();
        total++; if ({res_valid, res_carry, res_sum, res_id} !== {1'b1, 1'b1, 4'h0, 1'b1}) begin bad++;
            $display("FAIL ovf_f_plus_1: got v=%b c=%b s=%h id=%b want 1 1 0 1", res_valid, res_carry, res_sum, res_id); end
        drive(1'b0, 4'h0, 4'h0, 1'b1, 4'hF, 4'hF, 1'b1);
        next_cycle();
        total++; if ({res_valid, res_carry, res_sum, res_id} !== {1'b1, 1'b1, 4'hE, 1'b1}) begin bad++;
            $display("FAIL ovf_f_plus_f: got v=%b c=%b s=%h id=%b want 1 1 e 1", res_valid, res_carry, res_sum, res_id); end
        drive(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1);
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_rdy;
        logic [3:0] exp_sum;
        exp_rdy = 4'b0101;
        exp_sum = 4'h0;
        rst = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'h1, 4'h2, 1'b1, 4'h5, 4'h6, 1'b1);
            total++; if (req0_ready !== exp_rdy[i] || req1_ready !== !exp_rdy[i]) begin bad++;
                $display("FAIL b2b_grant%0d: got %b%b want %b%b", i, req0_ready, req1_ready, exp_rdy[i], !exp_rdy[i]); end
            next_cycle();
            exp_sum = exp_rdy[i] ? 4'h3 : 4'hB;
            total++; if ({res_valid, res_sum, res_id} !== {1'b1, exp_sum, !exp_rdy[i]}) begin bad++;
                $display("FAIL b2b_result%0d: got v=%b s=%h id=%b want 1 %h %b", i, res_valid, res_sum, res_id, exp_sum, !exp_rdy[i]); end
        end
    endtask

    // Entered FULL with requester-1 result 4'hB; pointer back at requester 0.
    task automatic test_backpressure();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'h1, 4'h2, 1'b1, 4'h5, 4'h6, 1'b0);
            total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++;
                $display("FAIL bp_readies%0d: got %b%b want 00", i, req0_ready, req1_ready); end
            total++; if ({res_valid, res_carry, res_sum, res_id} !== {1'b1, 1'b0, 4'hB, 1'b1}) begin bad++;
                $display("FAIL bp_stable%0d: got v=%b c=%b s=%h id=%b want 1 0 b 1", i, res_valid, res_carry, res_sum, res_id); end
            next_cycle();
        end
        drive(1'b1, 4'h1, 4'h2, 1'b1, 4'h5, 4'h6, 1'b1);
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++;
            $display("FAIL bp_release: got %b%b want 10", req0_ready, req1_ready); end
        next_cycle();
        total++; if ({res_valid, res_sum, res_id} !== {1'b1, 4'h3, 1'b0}) begin bad++;
            $display("FAIL bp_after: got v=%b s=%h id=%b want 1 3 0", res_valid, res_sum, res_id); end
    endtask

    // Pointer is at requester 1 here; reset must pull it back to 0.
    task automatic test_reset_while_full();
        rst = 1'b1;
        drive(1'b1, 4'h1, 4'h2, 1'b1, 4'h5, 4'h6, 1'b1);
        total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++;
            $display("FAIL rstfull_readies: got %b%b want 00", req0_ready, req1_ready); end
        next_cycle();
        rst = 1'b0;
        drive(1'b1, 4'h1, 4'h2, 1'b1, 4'h5, 4'h6, 1'b1);
        total++; if (res_valid !== 1'b0) begin bad++;
            $display("FAIL rstfull_valid: got %b want 0", res_valid); end
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++;
            $display("FAIL rstfull_first_grant: got %b%b want 10", req0_ready, req1_ready); end
        next_cycle();
        total++; if ({res_valid, res_sum, res_id} !== {1'b1, 4'h3, 1'b0}) begin bad++;
            $display("FAIL rstfull_result: got v=%b s=%h id=%b want 1 3 0", res_valid, res_sum, res_id); end
    endtask

    task automatic test_stress();
        logic [5:0] sb[$];
        logic [5:0] exp_w;
        logic       m_full;
        logic       m_ptr;
        logic       e0;
        logic       e1;
        logic       can;
        int         sb_bad;
        int         accepted;
        int         produced;
        sb_bad = 0; accepted = 0; produced = 0;
        rst = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
        next_cycle();
        rst = 1'b0;
        m_full = 1'b0;
        m_ptr  = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            drive(($urandom_range(0, 9) < 7), 4'($urandom), 4'($urandom),
                  ($urandom_range(0, 9) < 7), 4'($urandom), 4'($urandom),
                  ($urandom_range(0, 9) < 6));
            can = !m_full || res_ready;
            e0  = can && req0_valid && (!req1_valid || !m_ptr);
            e1  = can && req1_valid && (!req0_valid || m_ptr);
            total++; if (req0_ready !== e0 || req1_ready !== e1 || res_valid !== m_full) begin bad++;
                if (sb_bad < 5) $display("FAIL stress_ctrl c=%0d: got r=%b%b v=%b want r=%b%b v=%b",
                                         c, req0_ready, req1_ready, res_valid, e0, e1, m_full);
                sb_bad++; end
            if (m_full && res_ready) begin
                produced++;
                exp_w = (sb.size() > 0) ? sb.pop_front() : 6'h3F;
                total++; if ({res_carry, res_sum, res_id} !== exp_w) begin bad++;
                    if (sb_bad < 5) $display("FAIL stress_data c=%0d: got c=%b s=%h id=%b want c=%b s=%h id=%b",
                                             c, res_carry, res_sum, res_id, exp_w[5], exp_w[4:1], exp_w[0]);
                    sb_bad++; end
            end
            if (e0 || e1) begin
                accepted++;
                exp_w[5:1] = e1 ? ({1'b0, req1_a} + {1'b0, req1_b}) : ({1'b0, req0_a} + {1'b0, req0_b});
                exp_w[0]   = e1;
                sb.push_back(exp_w);
                m_full = 1'b1;
                m_ptr  = !e1;
            end else if (m_full && res_ready) begin
                m_full = 1'b0;
            end
            next_cycle();
        end
        total++; if (accepted - produced !== int'(m_full) || sb.size() !== int'(m_full)) begin bad++;
            $display("FAIL stress_count: accepted=%0d produced=%0d pending=%0d want pending=%0d",
                     accepted, produced, sb.size(), m_full); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req0_valid = 1'b0; req0_a = 4'h0; req0_b = 4'h0;
        req1_valid = 1'b0; req1_a = 4'h0; req1_b = 4'h0;
        res_ready  = 1'b0;
        next_cycle();
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_backpressure();
        test_reset_while_full();
        test_stress();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameters: none; operand width is fixed at 4 bits to match the shared 4-bit adder.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operand pair.
REQ-005 req0_a, req0_b  input  4 each  requester 0 operands.
REQ-006 req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_ready: same as REQ-004..006 for requester 1.
REQ-008 res_valid  output  1  result register holds a valid result.
REQ-009 res_ready  input  1  consumer accepts result this cycle.
REQ-010 res_sum  output  4  registered sum a+b mod 16.
REQ-011 res_carry  output  1  registered carry out (bit 4 of a+b).
REQ-012 res_id  output  1  requester that produced the result (0 or 1).

Function
REQ-013 A transfer on any port SHALL occur only on a cycle where its valid and ready are both 1.
REQ-014 The block SHALL hold a single-entry result register; state EMPTY (res_valid=0) or FULL (res_valid=1).
REQ-015 A grant SHALL be issued in a cycle when state is EMPTY, or FULL with res_ready=1 (drain and refill same cycle).
REQ-016 At most one of req0_ready/req1_ready SHALL be 1 per cycle; readies are combinational from valids, state, res_ready and priority pointer.
REQ-017 If only one requester is valid and a grant is allowed, that requester SHALL be granted.
REQ-018 If both are valid, the requester indicated by the round-robin pointer SHALL be granted.
REQ-019 After each grant the pointer SHALL point to the non-granted requester; without a grant it SHALL not change.
REQ-020 Operands granted in cycle T SHALL appear as res_sum/res_carry/res_id with res_valid=1 in cycle T+1 (latency 1, throughput 1/cycle).
REQ-021 Transitions: EMPTY+grant->FULL; FULL+res_ready+grant->FULL (new data); FULL+res_ready+no grant->EMPTY; FULL+!res_ready->FULL, outputs unchanged.
REQ-022 While res_valid=1 and res_ready=0, res_sum, res_carry and res_id SHALL remain stable.
REQ-023 Arithmetic: {res_carry,res_sum} SHALL equal the 5-bit sum of zero-extended operands; no carry-in.
REQ-024 Requester valid deasserting without a grant SHALL be legal and leave state unchanged.

Reset
REQ-025 While rst=1 at a rising edge: res_valid=0, res_sum=0, res_carry=0, res_id=0, pointer=requester 0.
REQ-026 During rst=1, req0_ready and req1_ready SHALL be 0.
REQ-027 A result pending when rst asserts SHALL be discarded; no transfer completes in a reset cycle.

Structure
REQ-028 Requester ID encodings (REQ_ID_0=0, REQ_ID_1=1) and width constant (4) SHALL live in the shared adder package/header.
REQ-029 The block SHALL instantiate exactly one adder_4bit as its sole sub-module; operand selection is a mux in front of it.
REQ-030 State SHALL be one FULL flag, one pointer bit and the result register; no other storage.

Verification
REQ-031 Reset then req0 only, a=4'h3 b=4'h4, res_ready=1 -> req0_ready=1 cycle T; cycle T+1 res_valid=1 sum=4'h7 carry=0 id=0.
REQ-032 Overflow: req1 a=4'hF b=4'h1 -> sum=4'h0 carry=1 id=1; a=4'hF b=4'hF -> sum=4'hE carry=1.
REQ-033 Both valid continuously, res_ready=1 -> grants alternate 0,1,0,1 from reset; res_valid stays 1, one result per cycle.
REQ-034 Backpressure: result FULL, res_ready=0 for 3 cycles with both requesters valid -> both readies 0, outputs stable; on res_ready=1 next grant goes to pointer owner.
REQ-035 rst asserted while FULL and requesters valid -> next cycle res_valid=0, readies 0, pointer=0; first post-reset grant with both valid goes to req0.
REQ-036 Random valid/ready stress 10k cycles against a scoreboard -> every accepted pair produces exactly one result in order with correct sum, carry and id.
